// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg
//   Shared types and constants for the bit-serial adder.
//   - state_e       : control FSM states (IDLE waits for Start, RUN adds one bit per clock)
//   - DEFAULT_WIDTH : default operand/sum width in bits
package serial_adder_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam int unsigned DEFAULT_WIDTH = 8;

endpackage : serial_adder_pkg

// File: rtl/full_adder_cell.sv
// full_adder_cell
//   Single-bit combinational full adder; the only arithmetic element of the
//   bit-serial adder.
//   Ports:
//     A, B  in  1  addend bits
//     Cin   in  1  carry in
//     S     out 1  sum bit        = A ^ B ^ Cin
//     Cout  out 1  carry out      = A&B | Cin&(A^B)
module full_adder_cell (
    input  logic A,
    input  logic B,
    input  logic Cin,
    output logic S,
    output logic Cout
);

    logic p;

    assign p    = A ^ B;
    assign S    = p ^ Cin;
    assign Cout = (A & B) | (Cin & p);

endmodule : full_adder_cell

// File: rtl/serial_adder.sv
// serial_adder
//   Bit-serial WIDTH-bit adder. On an accepted Start the operands and carry-in
//   are latched into shift registers; one bit pair is added per clock, LSB
//   first, through a single full-adder cell with a registered carry. After
//   WIDTH clocks the collected sum and final carry are loaded into the output
//   registers together with a one-cycle Done pulse.
//   Ports:
//     Clk    in   1      rising-edge clock
//     Rst_n  in   1      asynchronous active-low reset
//     Start  in   1      begin an addition (sampled only in IDLE)
//     A, B   in   WIDTH  operands (sampled on the accepted Start edge)
//     Cin    in   1      carry-in (sampled on the accepted Start edge)
//     Busy   out  1      addition in progress
//     Done   out  1      one-cycle pulse: S/Cout just updated
//     S      out  WIDTH  registered sum of the last completed addition
//     Cout   out  1      registered carry-out of the last completed addition
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             Start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] S,
    output logic             Cout
);

    localparam int unsigned     CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

    state_e           state_q,  state_d;
    logic [WIDTH-1:0] a_sh_q,   a_sh_d;
    logic [WIDTH-1:0] b_sh_q,   b_sh_d;
    logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
    logic             carry_q,  carry_d;
    logic [CW-1:0]    count_q,  count_d;
    logic [WIDTH-1:0] s_q,      s_d;
    logic             cout_q,   cout_d;
    logic             done_q,   done_d;

    logic             fa_s;
    logic             fa_c;

    full_adder_cell u_fa (
        .A    (a_sh_q[0]),
        .B    (b_sh_q[0]),
        .Cin  (carry_q),
        .S    (fa_s),
        .Cout (fa_c)
    );

    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        sum_sh_d = sum_sh_q;
        carry_d  = carry_q;
        count_d  = count_q;
        s_d      = s_q;
        cout_d   = cout_q;
        done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (Start) begin
                    a_sh_d   = A;
                    b_sh_d   = B;
                    sum_sh_d = '0;
                    carry_d  = Cin;
                    count_d  = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                a_sh_d   = {1'b0, a_sh_q[WIDTH-1:1]};
                b_sh_d   = {1'b0, b_sh_q[WIDTH-1:1]};
                // New sum bit enters at the MSB so that after WIDTH shifts
                // the first (LSB) sum bit has arrived at bit 0.
                sum_sh_d = {fa_s, sum_sh_q[WIDTH-1:1]};
                carry_d  = fa_c;
                count_d  = count_q + 1'b1;
                if (count_q == LAST) begin
                    // Output registers take the shifted value including this
                    // edge's sum bit; S never exposes partial results.
                    s_d     = sum_sh_d;
                    cout_d  = fa_c;
                    done_d  = 1'b1;
                    count_d = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q  <= IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            sum_sh_q <= '0;
            carry_q  <= 1'b0;
            count_q  <= '0;
            s_q      <= '0;
            cout_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            sum_sh_q <= sum_sh_d;
            carry_q  <= carry_d;
            count_q  <= count_d;
            s_q      <= s_d;
            cout_q   <= cout_d;
            done_q   <= done_d;
        end
    end

    // Busy decodes the state register directly, so it is still a registered
    // output with no path from any input.
    assign Busy = (state_q == RUN);
    assign Done = done_q;
    assign S    = s_q;
    assign Cout = cout_q;

endmodule : serial_adder

// File: tb/tb_serial_adder.sv
// tb_serial_adder
//   Directed bench for serial_adder (WIDTH=8). Expected {Cout,S} values are
//   computed from the operands and queued when Start is driven, then popped
//   and compared when Done is observed.
module tb_serial_adder;

    localparam int unsigned W = 8;

    typedef logic [W:0] res_t;

    logic         Clk = 1'b0;
    logic         Rst_n;
    logic         Start;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         Cin;
    logic         Busy;
    logic         Done;
    logic [W-1:0] S;
    logic         Cout;

    res_t sb[$];
    res_t last_res;
    int   tests = 0;
    int   fails = 0;

    serial_adder #(.WIDTH(W)) dut (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .Start (Start),
        .A     (A),
        .B     (B),
        .Cin   (Cin),
        .Busy  (Busy),
        .Done  (Done),
        .S     (S),
        .Cout  (Cout)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive a Start for one cycle from the current negedge; returns at the
    // negedge right after the accepting edge.
    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        Start = 1'b1;
        A     = a;
        B     = b;
        Cin   = c;
        sb.push_back(res_t'({1'b0, a}) + res_t'({1'b0, b}) + res_t'(c));
        @(negedge Clk);
        Start = 1'b0;
    endtask

    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        @(negedge Clk);
        launch(a, b, c);
    endtask

    // Called j0 cycles after the accepting edge; watches for Done within a
    // bounded number of cycles, checking Busy and held outputs meanwhile.
    task automatic wait_done(input string tag, input int j0);
        int   j    = j0;
        bit   seen = 1'b0;
        res_t exp;
        chk({tag, "_busy_start"}, 32'(Busy), 32'd1);
        while (!seen && j < int'(W) + 4) begin
            @(negedge Clk);
            j++;
            if (Done) seen = 1'b1;
            else begin
                chk({tag, "_busy_run"}, 32'(Busy), 32'd1);
                chk({tag, "_hold"}, 32'({Cout, S}), 32'(last_res));
            end
        end
        chk({tag, "_done_seen"}, 32'(seen), 32'd1);
        if (seen) begin
            chk({tag, "_latency"}, 32'(j), 32'(W));
            chk({tag, "_busy_end"}, 32'(Busy), 32'd0);
            chk({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                exp = sb.pop_front();
                chk({tag, "_result"}, 32'({Cout, S}), 32'(exp));
                last_res = exp;
            end
        end
    endtask

    task automatic quiet(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge Clk);
            chk({tag, "_no_done"}, 32'(Done), 32'd0);
            chk({tag, "_idle"}, 32'(Busy), 32'd0);
        end
    endtask

    initial begin
        Rst_n    = 1'b0;
        Start    = 1'b0;
        A        = '0;
        B        = '0;
        Cin      = 1'b0;
        last_res = '0;

        // Reset state
        #12;
        chk("rst_busy", 32'(Busy), 32'd0);
        chk("rst_done", 32'(Done), 32'd0);
        chk("rst_s",    32'(S),    32'd0);
        chk("rst_cout", 32'(Cout), 32'd0);
        @(negedge Clk);
        Rst_n = 1'b1;

        // 1: simple add
        start_op(8'h0F, 8'h01, 1'b0);
        wait_done("t1", 0);

        // 2: carry ripples through all bits
        start_op(8'hFF, 8'h01, 1'b1);
        wait_done("t2", 0);

        // 3: max operands, then all zero
        start_op(8'hFF, 8'hFF, 1'b1);
        wait_done("t3a", 0);
        start_op(8'h00, 8'h00, 1'b0);
        wait_done("t3b", 0);

        // 4: Start and operand change mid-run are ignored
        start_op(8'h12, 8'h34, 1'b0);
        repeat (2) @(negedge Clk);
        Start = 1'b1;
        A     = 8'hAA;
        @(negedge Clk);
        Start = 1'b0;
        wait_done("t4", 3);
        quiet("t4", int'(W) + 2);

        // 5: reset mid-run aborts
        start_op(8'h80, 8'h80, 1'b0);
        repeat (3) @(negedge Clk);
        @(posedge Clk);
        #2;
        Rst_n = 1'b0;
        #1;
        chk("t5_rst_s",    32'(S),    32'd0);
        chk("t5_rst_cout", 32'(Cout), 32'd0);
        chk("t5_rst_busy", 32'(Busy), 32'd0);
        chk("t5_rst_done", 32'(Done), 32'd0);
        void'(sb.pop_back());
        last_res = '0;
        @(negedge Clk);
        @(negedge Clk);
        Rst_n = 1'b1;
        quiet("t5", int'(W) + 2);
        start_op(8'h05, 8'h03, 1'b0);
        wait_done("t5b", 0);

        // 6: back-to-back, Start high during the Done cycle
        start_op(8'h10, 8'h20, 1'b0);
        wait_done("t6a", 0);
        launch(8'h01, 8'h02, 1'b0);
        wait_done("t6b", 0);
        @(negedge Clk);
        chk("t6_done_pulse", 32'(Done), 32'd0);

        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_serial_adder
